// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Byte width, FSM state encoding and word-size helper.
package instr_loader_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    WRITE,
    DONE
  } state_e;

  function automatic int bytes_per_word(input int dw);
    return dw / BYTE_W;
  endfunction

endpackage

// File: rtl/instr_loader.sv
// Byte-stream to instruction-memory loader.
// Packs bytes little-endian into words, writes them from address 0.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH:0]   word_count_i,
  input  logic                  byte_valid_i,
  input  logic [BYTE_W-1:0]     byte_i,
  output logic                  byte_ready_o,
  output logic                  we_o,
  output logic [ADDR_WIDTH-1:0] waddr_o,
  output logic [DATA_WIDTH-1:0] wdata_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BPW = bytes_per_word(DATA_WIDTH);
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);
  localparam logic [BCW-1:0] BC_ONE    = BCW'(1);

  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   W_ONE = (ADDR_WIDTH+1)'(1);

  // Largest load the memory can hold: 2**ADDR_WIDTH words.
  localparam logic [ADDR_WIDTH:0] MAX_WORDS =
    {1'b1, {ADDR_WIDTH{1'b0}}};

  state_e                  state_q;
  logic [BCW-1:0]          byte_cnt_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH:0]     words_left_q;
  logic [DATA_WIDTH-1:0]   asm_q;
  logic [DATA_WIDTH-1:0]   asm_nx;
  logic                    we_q;
  logic                    done_q;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;

  // Assembly word with the incoming byte dropped into its lane.
  always_comb begin
    asm_nx = asm_q;
    asm_nx[int'(byte_cnt_q)*BYTE_W +: BYTE_W] = byte_i;
  end

  // Loader FSM with byte assembler and registered write port.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      byte_cnt_q   <= '0;
      addr_q       <= '0;
      words_left_q <= '0;
      asm_q        <= '0;
      we_q         <= 1'b0;
      done_q       <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      we_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            if (word_count_i != '0) begin
              words_left_q <= (word_count_i > MAX_WORDS) ?
                              MAX_WORDS : word_count_i;
              addr_q       <= '0;
              byte_cnt_q   <= '0;
              asm_q        <= '0;
              state_q      <= RECV;
            end else begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RECV: begin
          if (byte_valid_i) begin
            asm_q <= asm_nx;
            if (byte_cnt_q == LAST_BYTE) begin
              we_q    <= 1'b1;
              waddr_q <= addr_q;
              wdata_q <= asm_nx;
              state_q <= WRITE;
            end else begin
              byte_cnt_q <= byte_cnt_q + BC_ONE;
            end
          end
        end
        WRITE: begin
          addr_q       <= addr_q + A_ONE;
          words_left_q <= words_left_q - W_ONE;
          byte_cnt_q   <= '0;
          asm_q        <= '0;
          if (words_left_q == W_ONE) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            state_q <= RECV;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign byte_ready_o = (state_q == RECV);
  assign busy_o       = (state_q != IDLE);
  assign we_o         = we_q;
  assign done_o       = done_q;
  assign waddr_o      = waddr_q;
  assign wdata_o      = wdata_q;

endmodule
